ddr2_axi_cmd_splitter: RTL and testbench

//  Front-end stage of the DDR2 controller, between the AXI4 AW/AR channels and the bank FSM.

---
 rtl/ddr2_pkg.sv | 26 ++
 rtl/ddr2_axi_cmd_splitter_if.sv | 51 +++++
 rtl/ddr2_addr_map.sv | 17 +
 rtl/ddr2_axi_cmd_splitter.sv | 186 ++++++++++++++++++
 tb/tb_ddr2_axi_cmd_splitter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr2_pkg.sv
// Shared types for the DDR2 command front end: the command record, the
// splitter state encoding and the AXI burst-type constant.
package ddr2_pkg;

   localparam int DDR2_BANK_WIDTH = 3;
   localparam int DDR2_ROW_WIDTH  = 14;
   localparam int DDR2_COL_WIDTH  = 10;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } split_state_t;

   // The record fixes the default DDR2 geometry; the splitter's width parameters must match it.
   typedef struct packed {
      logic                       write;
      logic [DDR2_BANK_WIDTH-1:0] bank;
      logic [DDR2_ROW_WIDTH-1:0]  row;
      logic [DDR2_COL_WIDTH-1:0]  col;
      logic [3:0]                 beats;
      logic                       last;
   } ddr2_cmd_t;

endpackage

// File: rtl/ddr2_axi_cmd_splitter_if.sv
// AXI AW/AR address channels plus the outgoing DDR2 command stream.
// The splitter connects through the slave modport; the upstream/bank side uses master.
interface ddr2_axi_cmd_splitter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BANK_WIDTH = 3,
   parameter int ROW_WIDTH  = 14,
   parameter int COL_WIDTH  = 10
);
   logic [ADDR_WIDTH-1:0] axi_awaddr;
   logic [7:0]            axi_awlen;
   logic [2:0]            axi_awsize;
   logic [1:0]            axi_awburst;
   logic                  axi_awvalid;
   logic                  axi_awready;

   logic [ADDR_WIDTH-1:0] axi_araddr;
   logic [7:0]            axi_arlen;
   logic [2:0]            axi_arsize;
   logic [1:0]            axi_arburst;
   logic                  axi_arvalid;
   logic                  axi_arready;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [BANK_WIDTH-1:0] cmd_bank;
   logic [ROW_WIDTH-1:0]  cmd_row;
   logic [COL_WIDTH-1:0]  cmd_col;
   logic [3:0]            cmd_beats;
   logic                  cmd_last;
   logic                  err_unsup;

   modport slave (
      input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
      input  axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
      input  cmd_ready,
      output axi_awready, axi_arready,
      output cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col, cmd_beats, cmd_last,
      output err_unsup
   );

   modport master (
      output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
      output axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
      output cmd_ready,
      input  axi_awready, axi_arready,
      input  cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col, cmd_beats, cmd_last,
      input  err_unsup
   );

endinterface

// File: rtl/ddr2_addr_map.sv
// Linear beat address -> column/bank/row decode; also used by the read-return path.
module ddr2_addr_map #(
   parameter int COL_WIDTH  = 10,
   parameter int BANK_WIDTH = 3,
   parameter int ROW_WIDTH  = 14
) (
   input  logic [COL_WIDTH+BANK_WIDTH+ROW_WIDTH-1:0] beat_addr,
   output logic [COL_WIDTH-1:0]                      col,
   output logic [BANK_WIDTH-1:0]                     bank,
   output logic [ROW_WIDTH-1:0]                      row
);

   assign col  = beat_addr[COL_WIDTH-1:0];
   assign bank = beat_addr[COL_WIDTH+BANK_WIDTH-1:COL_WIDTH];
   assign row  = beat_addr[COL_WIDTH+BANK_WIDTH+ROW_WIDTH-1:COL_WIDTH+BANK_WIDTH];

endmodule

// File: rtl/ddr2_axi_cmd_splitter.sv
// Round-robin AW/AR arbiter that splits AXI INCR bursts into aligned DDR2 column commands.
// Define DDR2_CMD_STATS_EN to add per-direction command counters and an unsupported-burst counter.
module ddr2_axi_cmd_splitter
   import ddr2_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int BANK_WIDTH  = DDR2_BANK_WIDTH,
   parameter int ROW_WIDTH   = DDR2_ROW_WIDTH,
   parameter int COL_WIDTH   = DDR2_COL_WIDTH,
   parameter int BURST_BEATS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   ddr2_axi_cmd_splitter_if.slave bus
`ifdef DDR2_CMD_STATS_EN
   ,
   output logic [31:0]            stat_wr_cmds,
   output logic [31:0]            stat_rd_cmds,
   output logic [15:0]            stat_unsup
`endif
);

   localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
   localparam int BB_LSB   = $clog2(BURST_BEATS);
   localparam int MAP_W    = COL_WIDTH + BANK_WIDTH + ROW_WIDTH;

   split_state_t          state_q, state_d;
   logic                  last_wr_q, last_wr_d;
   logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
   logic [8:0]            remaining_q, remaining_d;
   ddr2_cmd_t             cmd_q, cmd_d;
   logic                  cmd_valid_q, cmd_valid_d;
   logic                  err_unsup_q, err_unsup_d;

   logic                  in_idle, aw_grant, ar_grant, accept, unsup, cmd_fire;
   logic [ADDR_WIDTH-1:0] sel_addr, src_addr;
   logic [7:0]            sel_len;
   logic [2:0]            sel_size;
   logic [1:0]            sel_burst;
   logic [8:0]            src_rem;
   logic [3:0]            room, beats;
   logic [COL_WIDTH-1:0]  map_col;
   logic [BANK_WIDTH-1:0] map_bank;
   logic [ROW_WIDTH-1:0]  map_row;
   ddr2_cmd_t             new_cmd;

   // The next command is built from the incoming request in IDLE, from the saved cursor in SPLIT.
   always_comb begin
      in_idle   = (state_q == IDLE);
      aw_grant  = bus.axi_awvalid && (!bus.axi_arvalid || !last_wr_q);
      ar_grant  = bus.axi_arvalid && !aw_grant;
      accept    = in_idle && (aw_grant || ar_grant);
      sel_addr  = aw_grant ? bus.axi_awaddr  : bus.axi_araddr;
      sel_len   = aw_grant ? bus.axi_awlen   : bus.axi_arlen;
      sel_size  = aw_grant ? bus.axi_awsize  : bus.axi_arsize;
      sel_burst = aw_grant ? bus.axi_awburst : bus.axi_arburst;
      unsup     = (sel_burst != AXI_BURST_INCR) || (sel_size != 3'(ADDR_LSB));
      src_addr  = in_idle ? (sel_addr >> ADDR_LSB) : beat_addr_q;
      src_rem   = in_idle ? (9'(sel_len) + 9'd1) : remaining_q;
      room      = 4'(BURST_BEATS) - 4'(src_addr[BB_LSB-1:0]);
      beats     = (src_rem < 9'(room)) ? src_rem[3:0] : room;
      cmd_fire  = cmd_valid_q && bus.cmd_ready;

      new_cmd       = '0;
      new_cmd.write = in_idle ? aw_grant : cmd_q.write;
      new_cmd.bank  = map_bank;
      new_cmd.row   = map_row;
      new_cmd.col   = map_col;
      new_cmd.beats = beats;
      new_cmd.last  = (9'(beats) == src_rem);
   end

   ddr2_addr_map #(
      .COL_WIDTH  (COL_WIDTH),
      .BANK_WIDTH (BANK_WIDTH),
      .ROW_WIDTH  (ROW_WIDTH)
   ) u_addr_map (
      .beat_addr (src_addr[MAP_W-1:0]),
      .col       (map_col),
      .bank      (map_bank),
      .row       (map_row)
   );

   always_comb begin
      state_d     = state_q;
      last_wr_d   = last_wr_q;
      beat_addr_d = beat_addr_q;
      remaining_d = remaining_q;
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;
      err_unsup_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               last_wr_d = aw_grant;
               if (unsup) begin
                  err_unsup_d = 1'b1;
               end else begin
                  state_d     = SPLIT;
                  cmd_d       = new_cmd;
                  cmd_valid_d = 1'b1;
                  beat_addr_d = src_addr;
                  remaining_d = src_rem;
               end
            end
         end
         SPLIT: begin
            // A handshake always leaves one idle cycle before the next command is presented.
            if (cmd_fire) begin
               cmd_valid_d = 1'b0;
               beat_addr_d = beat_addr_q + ADDR_WIDTH'(cmd_q.beats);
               remaining_d = remaining_q - 9'(cmd_q.beats);
               if (cmd_q.last) state_d = IDLE;
            end else if (!cmd_valid_q) begin
               cmd_d       = new_cmd;
               cmd_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_wr_q   <= 1'b0;
         beat_addr_q <= '0;
         remaining_q <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         err_unsup_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_wr_q   <= last_wr_d;
         beat_addr_q <= beat_addr_d;
         remaining_q <= remaining_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         err_unsup_q <= err_unsup_d;
      end
   end

   assign bus.axi_awready = in_idle && aw_grant;
   assign bus.axi_arready = in_idle && ar_grant;
   assign bus.cmd_valid   = cmd_valid_q;
   assign bus.cmd_write   = cmd_q.write;
   assign bus.cmd_bank    = cmd_q.bank;
   assign bus.cmd_row     = cmd_q.row;
   assign bus.cmd_col     = cmd_q.col;
   assign bus.cmd_beats   = cmd_q.beats;
   assign bus.cmd_last    = cmd_q.last;
   assign bus.err_unsup   = err_unsup_q;

`ifdef DDR2_CMD_STATS_EN
   logic [31:0] stat_wr_q, stat_wr_d, stat_rd_q, stat_rd_d;
   logic [15:0] stat_unsup_q, stat_unsup_d;

   // Command counters wrap; the unsupported-burst counter saturates.
   always_comb begin
      stat_wr_d    = stat_wr_q;
      stat_rd_d    = stat_rd_q;
      stat_unsup_d = stat_unsup_q;
      if (cmd_fire && cmd_q.write)  stat_wr_d = stat_wr_q + 32'd1;
      if (cmd_fire && !cmd_q.write) stat_rd_d = stat_rd_q + 32'd1;
      if (err_unsup_q && (stat_unsup_q != 16'hFFFF)) stat_unsup_d = stat_unsup_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_wr_q    <= '0;
         stat_rd_q    <= '0;
         stat_unsup_q <= '0;
      end else begin
         stat_wr_q    <= stat_wr_d;
         stat_rd_q    <= stat_rd_d;
         stat_unsup_q <= stat_unsup_d;
      end
   end

   assign stat_wr_cmds = stat_wr_q;
   assign stat_rd_cmds = stat_rd_q;
   assign stat_unsup   = stat_unsup_q;
`endif

endmodule

// File: tb/tb_ddr2_axi_cmd_splitter.sv
// Scoreboard bench for ddr2_axi_cmd_splitter (DATA_WIDTH 64, BURST_BEATS 4).
module tb_ddr2_axi_cmd_splitter;

   typedef struct {
      logic        write;
      logic [2:0]  bank;
      logic [13:0] row;
      logic [9:0]  col;
      logic [3:0]  beats;
      logic        last;
   } exp_cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ddr2_axi_cmd_splitter_if #(.ADDR_WIDTH(32), .BANK_WIDTH(3), .ROW_WIDTH(14), .COL_WIDTH(10)) bus ();

`ifdef DDR2_CMD_STATS_EN
   logic [31:0] stat_wr_cmds, stat_rd_cmds;
   logic [15:0] stat_unsup;
`endif

   ddr2_axi_cmd_splitter #(
      .DATA_WIDTH(64), .ADDR_WIDTH(32), .BANK_WIDTH(3),
      .ROW_WIDTH(14), .COL_WIDTH(10), .BURST_BEATS(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef DDR2_CMD_STATS_EN
      ,
      .stat_wr_cmds (stat_wr_cmds),
      .stat_rd_cmds (stat_rd_cmds),
      .stat_unsup   (stat_unsup)
`endif
   );

   int       n_checks = 0;
   int       n_fail   = 0;
   exp_cmd_t exp_q[$];
   exp_cmd_t mon_e;

   // Every command handshake is checked against the head of the expectation queue.
   always @(negedge clk) begin
      if (!rst && bus.cmd_valid && bus.cmd_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL cmd_unexpected: got wr=%0b bank=%0h row=%0h col=%0h beats=%0d last=%0b, required no command",
                     bus.cmd_write, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_beats, bus.cmd_last);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.cmd_write, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_beats, bus.cmd_last} !==
                {mon_e.write, mon_e.bank, mon_e.row, mon_e.col, mon_e.beats, mon_e.last}) begin
               n_fail++;
               $display("[TB] FAIL cmd_fields: got wr=%0b bank=%0h row=%0h col=%0h beats=%0d last=%0b, required wr=%0b bank=%0h row=%0h col=%0h beats=%0d last=%0b",
                        bus.cmd_write, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_beats, bus.cmd_last,
                        mon_e.write, mon_e.bank, mon_e.row, mon_e.col, mon_e.beats, mon_e.last);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic push_cmd(input logic w, input logic [2:0] bank, input logic [13:0] row,
                           input logic [9:0] col, input logic [3:0] beats, input logic last);
      exp_cmd_t e;
      e.write = w; e.bank = bank; e.row = row; e.col = col; e.beats = beats; e.last = last;
      exp_q.push_back(e);
   endtask

   // Reference split: 8-byte beats, never crossing a 4-beat boundary.
   task automatic push_model(input logic [31:0] addr, input logic [7:0] len, input logic w);
      int unsigned beat;
      int rem, room, b;
      beat = addr >> 3;
      rem  = int'(len) + 1;
      while (rem > 0) begin
         room = 4 - int'(beat % 4);
         b    = (rem < room) ? rem : room;
         push_cmd(w, 3'((beat >> 10) & 7), 14'((beat >> 13) & 32'h3FFF), 10'(beat & 32'h3FF), 4'(b), b == rem);
         beat += b;
         rem  -= b;
      end
   endtask

   task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit done = 0;
      @(posedge clk); #1;
      bus.axi_awaddr = addr; bus.axi_awlen = len; bus.axi_awsize = size; bus.axi_awburst = burst;
      bus.axi_awvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (bus.axi_awready) done = 1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("[TB] FAIL aw_handshake: got awready=0 for 100 cycles, required 1");
      end
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0;
   endtask

   task automatic drive_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit done = 0;
      @(posedge clk); #1;
      bus.axi_araddr = addr; bus.axi_arlen = len; bus.axi_arsize = size; bus.axi_arburst = burst;
      bus.axi_arvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (bus.axi_arready) done = 1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("[TB] FAIL ar_handshake: got arready=0 for 100 cycles, required 1");
      end
      @(posedge clk); #1;
      bus.axi_arvalid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int i = 0;
      while (exp_q.size() != 0 && i < 300) begin
         @(negedge clk);
         i++;
      end
      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("[TB] FAIL %s_drain: got %0d commands missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awsize = 3'd3; bus.axi_awburst = 2'b01; bus.axi_awvalid = 1'b0;
      bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arsize = 3'd3; bus.axi_arburst = 2'b01; bus.axi_arvalid = 1'b0;
      bus.cmd_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.cmd_valid !== 1'b0) begin
         n_fail++; $display("[TB] FAIL reset_cmd_valid: got %b, required 0", bus.cmd_valid);
      end
      n_checks++;
      if ({bus.cmd_write, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_beats, bus.cmd_last} !== 33'd0) begin
         n_fail++; $display("[TB] FAIL reset_cmd_fields: got %h, required 0",
                            {bus.cmd_write, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_beats, bus.cmd_last});
      end
      n_checks++;
      if ({bus.err_unsup, bus.axi_awready, bus.axi_arready} !== 3'b000) begin
         n_fail++; $display("[TB] FAIL reset_flags: got err/awr/arr=%b, required 000",
                            {bus.err_unsup, bus.axi_awready, bus.axi_arready});
      end
`ifdef DDR2_CMD_STATS_EN
      n_checks++;
      if ({stat_wr_cmds, stat_rd_cmds, stat_unsup} !== 80'd0) begin
         n_fail++; $display("[TB] FAIL reset_stats: got wr=%0d rd=%0d unsup=%0d, required 0", stat_wr_cmds, stat_rd_cmds, stat_unsup);
      end
`endif
   endtask

   task automatic test_write_split();
      push_cmd(1'b1, 3'd0, 14'd0, 10'h200, 4'd4, 1'b0);
      push_cmd(1'b1, 3'd0, 14'd0, 10'h204, 4'd4, 1'b1);
      drive_aw(32'h0000_1000, 8'd7, 3'd3, 2'b01);
      @(negedge clk);
      n_checks++;
      if (bus.cmd_valid !== 1'b1) begin
         n_fail++; $display("[TB] FAIL first_cmd_latency: got cmd_valid=%b, required 1", bus.cmd_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus.cmd_valid !== 1'b0) begin
         n_fail++; $display("[TB] FAIL cmd_gap: got cmd_valid=%b, required 0", bus.cmd_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus.cmd_valid !== 1'b1) begin
         n_fail++; $display("[TB] FAIL second_cmd_valid: got cmd_valid=%b, required 1", bus.cmd_valid);
      end
      wait_drain("write_split");
`ifdef DDR2_CMD_STATS_EN
      n_checks++;
      if (stat_wr_cmds !== 32'd2) begin
         n_fail++; $display("[TB] FAIL stat_wr_cmds: got %0d, required 2", stat_wr_cmds);
      end
`endif
   endtask

   task automatic test_read_split();
      push_cmd(1'b0, 3'd0, 14'd0, 10'h021, 4'd3, 1'b0);
      push_cmd(1'b0, 3'd0, 14'd0, 10'h024, 4'd3, 1'b1);
      drive_ar(32'h0000_0108, 8'd5, 3'd3, 2'b01);
      wait_drain("read_split");
`ifdef DDR2_CMD_STATS_EN
      n_checks++;
      if (stat_rd_cmds !== 32'd2) begin
         n_fail++; $display("[TB] FAIL stat_rd_cmds: got %0d, required 2", stat_rd_cmds);
      end
`endif
   endtask

   task automatic test_col_wrap();
      push_cmd(1'b1, 3'd0, 14'd0, 10'h3FC, 4'd4, 1'b0);
      push_cmd(1'b1, 3'd1, 14'd0, 10'h000, 4'd4, 1'b1);
      drive_aw(32'h0000_1FE0, 8'd7, 3'd3, 2'b01);
      wait_drain("col_wrap");
   endtask

   task automatic test_backpressure();
      bus.cmd_ready = 1'b0;
      push_cmd(1'b1, 3'd1, 14'd0, 10'h000, 4'd4, 1'b0);
      push_cmd(1'b1, 3'd1, 14'd0, 10'h004, 4'd4, 1'b1);
      drive_aw(32'h0000_2000, 8'd7, 3'd3, 2'b01);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.cmd_valid, bus.cmd_write, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_beats, bus.cmd_last} !==
             {1'b1, 1'b1, 3'd1, 14'd0, 10'h000, 4'd4, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL stall_hold: cycle %0d got valid=%b bank=%0h col=%0h beats=%0d last=%b, required valid=1 bank=1 col=0 beats=4 last=0",
                     i, bus.cmd_valid, bus.cmd_bank, bus.cmd_col, bus.cmd_beats, bus.cmd_last);
         end
      end
      @(posedge clk); #1;
      bus.cmd_ready = 1'b1;
      wait_drain("backpressure");
   endtask

   task automatic test_random_bursts();
      logic [31:0] addr;
      logic [7:0]  len;
      for (int n = 0; n < 6; n++) begin
         addr = $urandom() & 32'hFFFF_FFF8;
         len  = 8'($urandom_range(0, 20));
         push_model(addr, len, n[0]);
         if (n[0]) drive_aw(addr, len, 3'd3, 2'b01);
         else      drive_ar(addr, len, 3'd3, 2'b01);
         wait_drain("random_burst");
      end
   endtask

   task automatic test_arbitration();
      bit got = 0;
      bit wr_done = 0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      push_cmd(1'b1, 3'd0, 14'd0, 10'h000, 4'd4, 1'b1);
      push_cmd(1'b0, 3'd0, 14'd0, 10'h008, 4'd2, 1'b1);
      bus.axi_awaddr = 32'h0; bus.axi_awlen = 8'd3; bus.axi_awsize = 3'd3; bus.axi_awburst = 2'b01;
      bus.axi_araddr = 32'h40; bus.axi_arlen = 8'd1; bus.axi_arsize = 3'd3; bus.axi_arburst = 2'b01;
      bus.axi_awvalid = 1'b1; bus.axi_arvalid = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.axi_awready, bus.axi_arready} !== 2'b10) begin
         n_fail++; $display("[TB] FAIL first_contention: got awready/arready=%b, required 10", {bus.axi_awready, bus.axi_arready});
      end
      @(posedge clk); #1 bus.axi_awvalid = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.axi_arready) got = 1;
         else if (bus.cmd_valid && bus.cmd_ready && bus.cmd_last && bus.cmd_write) wr_done = 1;
      end
      n_checks++;
      if (!got || !wr_done) begin
         n_fail++; $display("[TB] FAIL arready_after_wr_last: got arready_seen=%0b wr_last_before=%0b, required 1 1", got, wr_done);
      end
      @(posedge clk); #1 bus.axi_arvalid = 1'b0;
      wait_drain("arbitration");

      push_cmd(1'b1, 3'd0, 14'd0, 10'h010, 4'd1, 1'b1);
      drive_aw(32'h0000_0080, 8'd0, 3'd3, 2'b01);
      wait_drain("arb_single");
      push_cmd(1'b0, 3'd0, 14'd0, 10'h020, 4'd1, 1'b1);
      push_cmd(1'b1, 3'd0, 14'd0, 10'h040, 4'd1, 1'b1);
      bus.axi_araddr = 32'h100; bus.axi_arlen = 8'd0;
      bus.axi_awaddr = 32'h200; bus.axi_awlen = 8'd0;
      bus.axi_awvalid = 1'b1; bus.axi_arvalid = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.axi_awready, bus.axi_arready} !== 2'b01) begin
         n_fail++; $display("[TB] FAIL round_robin: got awready/arready=%b, required 01", {bus.axi_awready, bus.axi_arready});
      end
      @(posedge clk); #1 bus.axi_arvalid = 1'b0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.axi_awready) got = 1;
      end
      n_checks++;
      if (!got) begin
         n_fail++; $display("[TB] FAIL aw_after_ar: got awready=0 for 40 cycles, required 1");
      end
      @(posedge clk); #1 bus.axi_awvalid = 1'b0;
      wait_drain("round_robin");
   endtask

   task automatic test_unsup();
      int bad = 0;
      drive_ar(32'h0000_0300, 8'd3, 3'd3, 2'b10);
      @(negedge clk);
      n_checks++;
      if ({bus.err_unsup, bus.cmd_valid} !== 2'b10) begin
         n_fail++; $display("[TB] FAIL unsup_pulse: got err_unsup/cmd_valid=%b, required 10", {bus.err_unsup, bus.cmd_valid});
      end
      @(negedge clk);
      n_checks++;
      if (bus.err_unsup !== 1'b0) begin
         n_fail++; $display("[TB] FAIL unsup_one_cycle: got err_unsup=%b, required 0", bus.err_unsup);
      end
`ifdef DDR2_CMD_STATS_EN
      n_checks++;
      if (stat_unsup !== 16'd1) begin
         n_fail++; $display("[TB] FAIL stat_unsup: got %0d, required 1", stat_unsup);
      end
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.cmd_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("[TB] FAIL unsup_no_cmd: got %0d cycles with cmd_valid, required 0", bad);
      end
      drive_aw(32'h0000_0400, 8'd3, 3'd2, 2'b01);
      @(negedge clk);
      n_checks++;
      if ({bus.err_unsup, bus.cmd_valid} !== 2'b10) begin
         n_fail++; $display("[TB] FAIL unsup_size: got err_unsup/cmd_valid=%b, required 10", {bus.err_unsup, bus.cmd_valid});
      end
      repeat (2) @(posedge clk);
      #1;
`ifdef DDR2_CMD_STATS_EN
      n_checks++;
      if (stat_unsup !== 16'd2) begin
         n_fail++; $display("[TB] FAIL stat_unsup_2: got %0d, required 2", stat_unsup);
      end
`endif
   endtask

   task automatic test_reset_mid_burst();
      int bad = 0;
      bus.cmd_ready = 1'b0;
      drive_aw(32'h0000_3000, 8'd7, 3'd3, 2'b01);
      @(negedge clk);
      n_checks++;
      if (bus.cmd_valid !== 1'b1) begin
         n_fail++; $display("[TB] FAIL midburst_started: got cmd_valid=%b, required 1", bus.cmd_valid);
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.cmd_valid, bus.cmd_write, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_beats, bus.cmd_last} !== 34'd0) begin
         n_fail++; $display("[TB] FAIL midburst_reset_outputs: got %h, required 0",
                            {bus.cmd_valid, bus.cmd_write, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_beats, bus.cmd_last});
      end
      bus.cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.cmd_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("[TB] FAIL midburst_abandoned: got %0d cycles with cmd_valid, required 0", bad);
      end
      push_cmd(1'b1, 3'd0, 14'd0, 10'h008, 4'd2, 1'b1);
      drive_aw(32'h0000_0040, 8'd1, 3'd3, 2'b01);
      wait_drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_write_split();
      test_read_split();
      test_col_wrap();
      test_backpressure();
      test_random_bursts();
      test_arbitration();
      test_unsup();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
